// File: rtl/audio_tone_gen_pkg.sv
// Shared types and constants for the audio tone generator: FSM states,
// counter widths and the half-period table for a 50 MHz clock.
package audio_tone_gen_pkg;

  localparam int PWM_BITS = 5;
  localparam int SEL_BITS = 4;
  localparam int HP_BITS  = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } toneState_e;

  // Half-period in clocks = 25e6 / f; index 1 is C5, each step one semitone up
  localparam logic [HP_BITS-1:0] TONE_HALF_PERIOD [0:15] = '{
    17'd0,     17'd47778, 17'd45097, 17'd42566,
    17'd40177, 17'd37922, 17'd35793, 17'd33784,
    17'd31888, 17'd30098, 17'd28409, 17'd26815,
    17'd25310, 17'd23889, 17'd22548, 17'd21283
  };

endpackage

// File: rtl/audio_tone_gen_if.sv
// Command and audio output bundle between the decode stage and the tone generator.
interface audio_tone_gen_if;
  import audio_tone_gen_pkg::*;

  logic                audio_en;
  logic [SEL_BITS-1:0] audio_sel;
  logic [PWM_BITS-1:0] audio_vol;
  logic                audio_pwm;
  logic                tone_sq;
  logic                playing;

  modport master (
    output audio_en, audio_sel, audio_vol,
    input  audio_pwm, tone_sq, playing
  );

  modport slave (
    input  audio_en, audio_sel, audio_vol,
    output audio_pwm, tone_sq, playing
  );

endinterface

// File: rtl/audio_tone_gen_tone_rom.sv
// Combinational lookup from tone select to square-wave half-period in clocks.
module tone_rom
  import audio_tone_gen_pkg::*;
(
  input  logic [SEL_BITS-1:0] i_sel,
  output logic [HP_BITS-1:0]  o_halfPeriod
);

  assign o_halfPeriod = TONE_HALF_PERIOD[i_sel];

endmodule

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator: a command strobe loads tone/volume, the note
// plays as a PWM-gated square wave until replaced, timed out or reset.
module audio_tone_gen
  import audio_tone_gen_pkg::*;
#(
  parameter int unsigned DUR_CYCLES = 0
)
(
  input logic             clk,
  input logic             reset,
  audio_tone_gen_if.slave bus
);

  localparam logic [31:0] DUR_LAST = (DUR_CYCLES == 0) ? 32'd0 : 32'(DUR_CYCLES - 1);

  toneState_e          r_state;
  toneState_e          w_nextState;
  logic [SEL_BITS-1:0] r_curSel;
  logic [PWM_BITS-1:0] r_curVol;
  logic [HP_BITS-1:0]  r_hpCnt;
  logic [31:0]         r_durCnt;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                r_toneSq;
  logic                r_audioPwm;
  logic                r_playing;
  logic [HP_BITS-1:0]  w_halfPeriod;
  logic                w_durDone;
  logic                w_hpWrap;

  tone_rom u_toneRom (
    .i_sel        (r_curSel),
    .o_halfPeriod (w_halfPeriod)
  );

  assign w_durDone = (DUR_CYCLES != 0) && (r_durCnt == DUR_LAST);
  assign w_hpWrap  = (r_hpCnt == w_halfPeriod - 17'd1);

  // A strobe arriving while in LOAD is deliberately not looked at
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: if (bus.audio_en) w_nextState = LOAD;
      LOAD: begin
        if ((bus.audio_sel == '0) || (bus.audio_vol == '0)) w_nextState = IDLE;
        else                                                w_nextState = PLAY;
      end
      PLAY: begin
        if (bus.audio_en)   w_nextState = LOAD;
        else if (w_durDone) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_playing <= (w_nextState == PLAY);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_curSel <= '0;
      r_curVol <= '0;
    end else if (r_state == LOAD) begin
      r_curSel <= bus.audio_sel;
      r_curVol <= bus.audio_vol;
    end
  end

  // Same-tone reloads keep the running phase so a volume change cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpCnt  <= '0;
      r_toneSq <= 1'b0;
    end else begin
      unique case (r_state)
        PLAY: begin
          if (w_nextState == IDLE) begin
            r_hpCnt  <= '0;
            r_toneSq <= 1'b0;
          end else if (w_hpWrap) begin
            r_hpCnt  <= '0;
            r_toneSq <= ~r_toneSq;
          end else begin
            r_hpCnt  <= r_hpCnt + 17'd1;
          end
        end
        LOAD: begin
          if ((w_nextState == IDLE) || (bus.audio_sel != r_curSel)) begin
            r_hpCnt  <= '0;
            r_toneSq <= 1'b0;
          end
        end
        default: begin
          r_hpCnt  <= '0;
          r_toneSq <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_durCnt <= '0;
    end else if (r_state == PLAY) begin
      r_durCnt <= r_durCnt + 32'd1;
    end else begin
      r_durCnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwmCnt   <= '0;
      r_audioPwm <= 1'b0;
    end else begin
      r_pwmCnt   <= r_pwmCnt + 5'd1;
      r_audioPwm <= (r_state == PLAY) && r_toneSq && (r_pwmCnt < r_curVol);
    end
  end

  assign bus.audio_pwm = r_audioPwm;
  assign bus.tone_sq   = r_toneSq;
  assign bus.playing   = r_playing;

endmodule

// File: doc/audio_tone_gen.md
AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 SHALL have parameter: DUR_CYCLES, 0, note length in clk cycles (0 = sustain until next command).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: audio_en  input  1  one-cycle command strobe from decode stage.
REQ-005 SHALL have port: audio_sel  input  4  tone select, registered upstream; valid the cycle after audio_en.
REQ-006 SHALL have port: audio_vol  input  5  volume, registered upstream; valid the cycle after audio_en.
REQ-007 SHALL have port: audio_pwm  output  1  volume-modulated square wave to speaker.
REQ-008 SHALL have port: tone_sq  output  1  raw square wave, before volume gating.
REQ-009 SHALL have port: playing  output  1  high while in PLAY.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, PLAY.
REQ-011 IDLE: audio_en -> LOAD; else stay; tone_sq and audio_pwm held 0.
REQ-012 LOAD (exactly one cycle): latch audio_sel into cur_sel, audio_vol into cur_vol; next state IDLE if sampled sel==0 or vol==0, else PLAY.
REQ-013 PLAY: audio_en -> LOAD; else if DUR_CYCLES!=0 and duration counter reaches DUR_CYCLES-1 -> IDLE; else stay.
REQ-014 audio_en in LOAD SHALL be ignored (strobe cannot be back-to-back from decode).
REQ-015 Half-period counter hp_cnt (17 bit) SHALL increment each PLAY cycle; at TONE_HALF_PERIOD[cur_sel]-1 it SHALL wrap to 0 and toggle tone_sq.
REQ-016 LOAD with new sel != previous cur_sel SHALL clear hp_cnt and tone_sq (phase restart); equal sel SHALL keep hp_cnt and tone_sq (volume-only update, no glitch).
REQ-017 Duration counter SHALL clear on every LOAD and increment each PLAY cycle.
REQ-018 pwm_cnt (5 bit) SHALL free-run 0..31 and wrap, in all states, from reset.
REQ-019 audio_pwm SHALL be registered: audio_pwm <= (state==PLAY) & tone_sq & (pwm_cnt < cur_vol); one-cycle latency from its terms.
REQ-020 Leaving PLAY SHALL clear tone_sq, hp_cnt, and audio_pwm on the following edge.
REQ-021 playing SHALL equal (state==PLAY), registered.

Reset
REQ-022 Reset SHALL force state IDLE; cur_sel, cur_vol, hp_cnt, duration counter, pwm_cnt, tone_sq, audio_pwm, playing all 0.
REQ-023 Reset asserted mid-note SHALL silence outputs immediately (asynchronously); first command after release SHALL behave as from power-up.

Structure
REQ-024 Shared package SHALL hold state enum (IDLE, LOAD, PLAY), TONE_HALF_PERIOD[0:15] 17-bit constant table (50 MHz clk; entry0=0 unused, entry1=47778 for C5, entry13=23889 for C6, remaining chromatic steps), and PWM_BITS=5.
REQ-025 Tone lookup SHALL be a separate combinational sub-module tone_rom (4-bit sel in, 17-bit half-period out).

Verification
REQ-026 Reset then audio_en with sel=1, vol=31 next cycle -> playing high 2 cycles after strobe; tone_sq toggles every 47778 cycles; audio_pwm high 31 of 32 cycles while tone_sq=1.
REQ-027 In PLAY sel=1, issue command sel=1 vol=8 mid half-period -> no tone_sq phase jump; audio_pwm duty drops to 8/32 of high half.
REQ-028 In PLAY sel=1, command sel=13 -> hp_cnt and tone_sq cleared in LOAD; subsequent toggles every 23889 cycles.
REQ-029 Command sel=0 (any vol) or vol=0 (any sel) -> LOAD then IDLE; playing=0, audio_pwm=0 thereafter.
REQ-030 DUR_CYCLES=1000, sel=1 vol=16 -> playing high exactly 1000 cycles then IDLE; outputs 0 next edge.
REQ-031 Assert reset mid-note for 3 cycles -> audio_pwm, tone_sq, playing drop to 0 without waiting for clk; next command restarts phase at hp_cnt=0.
